// File: rtl/rf_access_pkg.sv
// rf_access_pkg: shared definitions for the register-file access controller.
//   state_t       - controller FSM states
//   WB_SRC_*      - encoding of the writeback source select
//   TIMEOUT_DATA  - value returned for an operand whose RF read timed out
package rf_access_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_REL = 3'd2,
        RD_REQ = 3'd3,
        RD_REL = 3'd4,
        RSP    = 3'd5
    } state_t;

    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_LSU = 1'b1;

    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/rf_hs_port.sv
// rf_hs_port: one four-phase req/ack channel towards the register file.
// Ports:
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   start       - raise req on the next edge
//   abort       - drop req on the next edge without a completed ack
//   ack         - acknowledge from the register file
//   req         - request to the register file (registered)
//   hit         - ack accepted this cycle; req drops on the next edge
// An ack that is already high when the request is raised is stale (left
// over from the previous transfer), so the channel only arms once ack has
// been observed low while req is asserted.
module rf_hs_port (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic ack,
    output logic req,
    output logic hit
);

    logic armed;

    assign hit = req && armed && ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req   <= 1'b0;
            armed <= 1'b0;
        end else if (start) begin
            req   <= 1'b1;
            armed <= !ack;
        end else if (hit || abort) begin
            req   <= 1'b0;
            armed <= 1'b0;
        end else if (req && !ack) begin
            armed <= 1'b1;
        end
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: serialises operand fetches and writebacks onto a
// four-phase register-file interface.
// Ports:
//   clk_i, rst_ni                  - clock, asynchronous active-low reset
//   rd_valid_i/rd_ready_o          - operand fetch request (raddr_*, use_*)
//   rsp_valid_o/rsp_ready_i        - operand response (rdata_a_o, rdata_b_o)
//   wb_valid_i/wb_ready_o          - writeback (wb_addr_i, wb_src_i, data)
//   rf_req_*_o / rf_ack_*_i        - RF four-phase handshakes (ra, rb, w)
//   rf_raddr_*, rf_waddr_o, rf_wdata_*_o, rf_soursel_o, rf_rdata_*_i
//   err_timeout_o                  - sticky timeout flag
// Build option: define RF_ACCESS_TIMEOUT_EN to bound each RF request to
// TimeoutCycles cycles; without it requests wait indefinitely and
// err_timeout_o is constant 0.
module rf_access_ctrl
    import rf_access_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rd_valid_i,
    output logic        rd_ready_o,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    input  logic        use_a_i,
    input  logic        use_b_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o,
    input  logic        wb_valid_i,
    output logic        wb_ready_o,
    input  logic [4:0]  wb_addr_i,
    input  logic        wb_src_i,
    input  logic [31:0] wb_data_alu_i,
    input  logic [31:0] wb_data_lsu_i,
    output logic        rf_req_ra_o,
    output logic        rf_req_rb_o,
    output logic        rf_req_w_o,
    input  logic        rf_ack_ra_i,
    input  logic        rf_ack_rb_i,
    input  logic        rf_ack_w_i,
    output logic [4:0]  rf_raddr_a_o,
    output logic [4:0]  rf_raddr_b_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_alu_o,
    output logic [31:0] rf_wdata_lsu_o,
    output logic        rf_soursel_o,
    input  logic [31:0] rf_rdata_a_i,
    input  logic [31:0] rf_rdata_b_i,
    output logic        err_timeout_o
);

    if (TimeoutCycles < 1) begin : g_cfg_check
        $error("TimeoutCycles must be at least 1");
    end

    state_t state;
    logic   issued_a, issued_b;
    logic   accept_wb, accept_rd;
    logic   need_a, need_b;
    logic   hit_ra, hit_rb, hit_w;
    logic   wr_done, rd_done;
    logic   timeout, abort_w, abort_rd;

    // Writeback wins over a simultaneous read so a read never overtakes an
    // older write to the same register.
    assign wb_ready_o  = (state == IDLE);
    assign rd_ready_o  = (state == IDLE) && !wb_valid_i;
    assign rsp_valid_o = (state == RSP);

    assign accept_wb = wb_valid_i && wb_ready_o;
    assign accept_rd = rd_valid_i && rd_ready_o;

    // Register 0 reads as zero and unused operands need no RF traffic.
    assign need_a = use_a_i && (raddr_a_i != 5'd0);
    assign need_b = use_b_i && (raddr_b_i != 5'd0);

    assign wr_done = hit_w;
    assign rd_done = (!rf_req_ra_o || hit_ra) && (!rf_req_rb_o || hit_rb);

`ifdef RF_ACCESS_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] tcnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt <= '0;
        end else if (state == WR_REQ || state == RD_REQ) begin
            tcnt <= tcnt + 1'b1;
        end else begin
            tcnt <= '0;
        end
    end

    // Fires on the TimeoutCycles-th cycle spent waiting in a REQ state.
    assign timeout = (state == WR_REQ || state == RD_REQ)
                     && (tcnt == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_timeout_o <= 1'b0;
        end else if (abort_w || abort_rd) begin
            err_timeout_o <= 1'b1;
        end
    end
`else
    assign timeout       = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

    // A completion on the same edge as the timeout takes precedence.
    assign abort_w  = (state == WR_REQ) && timeout && !wr_done;
    assign abort_rd = (state == RD_REQ) && timeout && !rd_done;

    rf_hs_port u_port_ra (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .start (accept_rd && need_a),
        .abort (abort_rd),
        .ack   (rf_ack_ra_i),
        .req   (rf_req_ra_o),
        .hit   (hit_ra)
    );

    rf_hs_port u_port_rb (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .start (accept_rd && need_b),
        .abort (abort_rd),
        .ack   (rf_ack_rb_i),
        .req   (rf_req_rb_o),
        .hit   (hit_rb)
    );

    rf_hs_port u_port_w (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .start (accept_wb),
        .abort (abort_w),
        .ack   (rf_ack_w_i),
        .req   (rf_req_w_o),
        .hit   (hit_w)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            issued_a       <= 1'b0;
            issued_b       <= 1'b0;
            rf_waddr_o     <= '0;
            rf_wdata_alu_o <= '0;
            rf_wdata_lsu_o <= '0;
            rf_soursel_o   <= WB_SRC_ALU;
            rf_raddr_a_o   <= '0;
            rf_raddr_b_o   <= '0;
            rdata_a_o      <= '0;
            rdata_b_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_wb) begin
                        rf_waddr_o     <= wb_addr_i;
                        rf_wdata_alu_o <= wb_data_alu_i;
                        rf_wdata_lsu_o <= wb_data_lsu_i;
                        rf_soursel_o   <= wb_src_i;
                        state          <= WR_REQ;
                    end else if (accept_rd) begin
                        rf_raddr_a_o <= raddr_a_i;
                        rf_raddr_b_o <= raddr_b_i;
                        issued_a     <= need_a;
                        issued_b     <= need_b;
                        rdata_a_o    <= '0;
                        rdata_b_o    <= '0;
                        state        <= (need_a || need_b) ? RD_REQ : RSP;
                    end
                end
                WR_REQ: begin
                    if (wr_done || abort_w) begin
                        state <= WR_REL;
                    end
                end
                WR_REL: begin
                    if (!rf_ack_w_i) begin
                        state <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (hit_ra) begin
                        rdata_a_o <= rf_rdata_a_i;
                    end else if (abort_rd && rf_req_ra_o) begin
                        rdata_a_o <= TIMEOUT_DATA;
                    end
                    if (hit_rb) begin
                        rdata_b_o <= rf_rdata_b_i;
                    end else if (abort_rd && rf_req_rb_o) begin
                        rdata_b_o <= TIMEOUT_DATA;
                    end
                    if (rd_done || abort_rd) begin
                        state <= RD_REL;
                    end
                end
                RD_REL: begin
                    if ((!issued_a || !rf_ack_ra_i) && (!issued_b || !rf_ack_rb_i)) begin
                        state <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
